next_pc_unit: RTL and testbench

- Parametrised next-address generator and program-counter register for the single-issue datapath; successor to the fixed 10-bit next-address logic.
- Owns the PC register and evaluates the 4-bit branch condition against the 4-bit flag vector.
- Selects the next PC from sequential, conditional-jump, register-jump, halt/zero, call and return sources.
- Adds a circular return-address stack (RAS), a stall hold and sticky stack-error flags.

---
 rtl/next_pc_unit.sv | 146 ++++++++++++++
 tb/tb_next_pc_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// Next-address generator and PC register with a circular return-address stack.
// Evaluates branch conditions, selects the next PC and keeps sticky RAS error flags.
module next_pc_unit #(
   parameter int                AW        = 10,
   parameter int                INCR_W    = 32,
   parameter int                RAS_DEPTH = 4,
   parameter logic [AW-1:0]     RESET_PC  = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stall,
   input  logic [2:0]                    sel,
   input  logic [AW-1:0]                 jta,
   input  logic [AW-1:0]                 reg_val,
   input  logic [3:0]                    brc,
   input  logic [3:0]                    flags,
   output logic [AW-1:0]                 pc,
   output logic [AW-1:0]                 next_pc,
   output logic [INCR_W-1:0]             incr_pc,
   output logic                          taken,
   output logic [$clog2(RAS_DEPTH):0]    ras_count,
   output logic                          ras_ovf,
   output logic                          ras_unf
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [2:0] SEL_SEQ  = 3'b000;
   localparam logic [2:0] SEL_COND = 3'b001;
   localparam logic [2:0] SEL_REG  = 3'b010;
   localparam logic [2:0] SEL_ZERO = 3'b011;
   localparam logic [2:0] SEL_CALL = 3'b100;
   localparam logic [2:0] SEL_RET  = 3'b101;

   localparam logic [AW-1:0] ONE_A  = AW'(1);
   localparam logic [PW-1:0] ONE_P  = PW'(1);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [CW-1:0] FULL_C = CW'(RAS_DEPTH);
   localparam logic [AW-1:0] RESET_SEQ = RESET_PC + ONE_A;

   logic [AW-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0] ras_ptr;
   logic [AW-1:0] seq;
   logic [AW-1:0] ras_top;
   logic          cond_ok;
   logic          ras_empty;
   logic          ras_full;
   logic          do_push;
   logic          do_pop;
   logic          unf_evt;

   assign seq       = pc + ONE_A;
   assign ras_empty = (ras_count == '0);
   assign ras_full  = (ras_count == FULL_C);
   // ras_ptr is the next write slot, so the top sits one below it
   assign ras_top   = ras_mem[ras_ptr - ONE_P];

   always_comb begin
      cond_ok = 1'b0;
      unique case (brc)
         4'd0:    cond_ok = 1'b1;
         4'd1:    cond_ok = flags[3];
         4'd2:    cond_ok = !flags[3];
         4'd3:    cond_ok = flags[2];
         4'd4:    cond_ok = !flags[2];
         4'd5:    cond_ok = flags[1];
         4'd6:    cond_ok = !flags[1];
         4'd7:    cond_ok = flags[0];
         4'd8:    cond_ok = !flags[0];
         default: cond_ok = 1'b0;
      endcase
   end

   always_comb begin
      next_pc = seq;
      taken   = 1'b0;
      do_push = 1'b0;
      do_pop  = 1'b0;
      unf_evt = 1'b0;
      unique case (sel)
         SEL_COND: begin
            if (cond_ok) begin
               next_pc = jta;
               taken   = 1'b1;
            end
         end
         SEL_REG: begin
            next_pc = reg_val;
            taken   = 1'b1;
         end
         SEL_ZERO: begin
            next_pc = '0;
            taken   = 1'b1;
         end
         SEL_CALL: begin
            next_pc = jta;
            taken   = 1'b1;
            do_push = 1'b1;
         end
         SEL_RET: begin
            if (!ras_empty) begin
               next_pc = ras_top;
               taken   = 1'b1;
               do_pop  = 1'b1;
            end else begin
               unf_evt = 1'b1;
            end
         end
         default: begin
            next_pc = seq;
            taken   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         incr_pc   <= INCR_W'(RESET_SEQ);
         ras_ptr   <= '0;
         ras_count <= '0;
         ras_ovf   <= 1'b0;
         ras_unf   <= 1'b0;
      end else if (!stall) begin
         pc      <= next_pc;
         incr_pc <= INCR_W'(seq);
         if (do_push) begin
            // A full stack wraps onto its oldest entry
            ras_ptr <= ras_ptr + ONE_P;
            if (ras_full) ras_ovf <= 1'b1;
            else ras_count <= ras_count + ONE_C;
         end
         if (do_pop) begin
            ras_ptr   <= ras_ptr - ONE_P;
            ras_count <= ras_count - ONE_C;
         end
         if (unf_evt) ras_unf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !stall && do_push) ras_mem[ras_ptr] <= seq;
   end

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: vector table, directed sequences
// and random stimulus against a queue-based reference model.
module tb_next_pc_unit;

   localparam int AW = 10;
   localparam int IW = 32;
   localparam int D  = 4;
   localparam logic [AW-1:0] RPC = 10'h000;

   logic          clk;
   logic          rst;
   logic          stall;
   logic [2:0]    sel;
   logic [AW-1:0] jta;
   logic [AW-1:0] reg_val;
   logic [3:0]    brc;
   logic [3:0]    flags;
   logic [AW-1:0] pc;
   logic [AW-1:0] next_pc;
   logic [IW-1:0] incr_pc;
   logic          taken;
   logic [2:0]    ras_count;
   logic          ras_ovf;
   logic          ras_unf;

   next_pc_unit #(
      .AW(AW), .INCR_W(IW), .RAS_DEPTH(D), .RESET_PC(RPC)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .sel(sel),
      .jta(jta), .reg_val(reg_val), .brc(brc), .flags(flags),
      .pc(pc), .next_pc(next_pc), .incr_pc(incr_pc), .taken(taken),
      .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [AW-1:0] m_pc;
   logic [IW-1:0] m_incr;
   int            m_ras[$];
   bit            m_ovf;
   bit            m_unf;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_cond(input logic [3:0] f, input int b);
      int idx;
      if (b == 0) return 1'b1;
      if (b > 8) return 1'b0;
      idx = 3 - (b - 1) / 2;
      if (b % 2 == 1) return f[idx];
      return !f[idx];
   endfunction

   task automatic model_next(input logic [2:0] sl, input logic [AW-1:0] jt,
                             input logic [AW-1:0] rv, input logic [3:0] b,
                             input logic [3:0] f,
                             output logic [AW-1:0] np, output bit tk);
      logic [AW-1:0] s;
      s  = m_pc + 1'b1;
      np = s;
      tk = 1'b0;
      if (sl == 3'd1 && model_cond(f, int'(b))) begin np = jt; tk = 1'b1; end
      else if (sl == 3'd2) begin np = rv; tk = 1'b1; end
      else if (sl == 3'd3) begin np = '0; tk = 1'b1; end
      else if (sl == 3'd4) begin np = jt; tk = 1'b1; end
      else if (sl == 3'd5 && m_ras.size() > 0) begin
         np = AW'(m_ras[$]);
         tk = 1'b1;
      end
   endtask

   task automatic step(input bit r, input bit s, input logic [2:0] sl,
                       input logic [AW-1:0] jt, input logic [AW-1:0] rv,
                       input logic [3:0] b, input logic [3:0] f);
      logic [AW-1:0] np;
      logic [AW-1:0] sq;
      logic [AW-1:0] rs;
      bit tk;
      rst = r; stall = s; sel = sl; jta = jt;
      reg_val = rv; brc = b; flags = f;
      #1;
      if (!r) begin
         model_next(sl, jt, rv, b, f, np, tk);
         chk("next_pc", next_pc, np);
         chk("taken", taken, tk);
      end
      @(posedge clk);
      if (r) begin
         rs = RPC + 1'b1;
         m_pc = RPC; m_incr = IW'(rs);
         m_ras.delete(); m_ovf = 0; m_unf = 0;
      end else if (!s) begin
         sq = m_pc + 1'b1;
         if (sl == 3'd4) begin
            if (m_ras.size() == D) begin
               void'(m_ras.pop_front());
               m_ovf = 1;
            end
            m_ras.push_back(int'(sq));
         end
         if (sl == 3'd5) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            else m_unf = 1;
         end
         m_incr = IW'(sq);
         m_pc = np;
      end
      @(negedge clk);
      chk("pc", pc, m_pc);
      chk("incr_pc", incr_pc, m_incr);
      chk("ras_count", ras_count, m_ras.size());
      chk("ras_ovf", ras_ovf, m_ovf);
      chk("ras_unf", ras_unf, m_unf);
   endtask

   typedef struct {
      logic [3:0] f;
      logic [3:0] b;
      bit         tk;
   } vec_t;

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{4'b1000, 4'd1, 1'b1};
      tbl[1]  = '{4'b1000, 4'd2, 1'b0};
      tbl[2]  = '{4'b1000, 4'd9, 1'b0};
      tbl[3]  = '{4'b0100, 4'd3, 1'b1};
      tbl[4]  = '{4'b0100, 4'd4, 1'b0};
      tbl[5]  = '{4'b0010, 4'd5, 1'b1};
      tbl[6]  = '{4'b0000, 4'd6, 1'b1};
      tbl[7]  = '{4'b0001, 4'd7, 1'b1};
      tbl[8]  = '{4'b0001, 4'd8, 1'b0};
      tbl[9]  = '{4'b1111, 4'd0, 1'b1};
      tbl[10] = '{4'b1111, 4'd15, 1'b0};
      tbl[11] = '{4'b0111, 4'd1, 1'b0};

      m_pc = '0; m_incr = '0; m_ovf = 0; m_unf = 0;
      rst = 1; stall = 0; sel = 0; jta = 0;
      reg_val = 0; brc = 0; flags = 0;

      step(1, 0, 3'd0, 0, 0, 0, 0);
      step(1, 0, 3'd0, 0, 0, 0, 0);
      chk("reset_pc", pc, 10'h000);
      chk("reset_incr", incr_pc, 32'd1);
      for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 0, 0, 0, 0);
      chk("seq3_pc", pc, 10'h003);
      chk("seq3_incr", incr_pc, 32'd3);

      step(0, 0, 3'd2, 0, 10'h3FF, 0, 0);
      step(0, 0, 3'd0, 0, 0, 0, 0);
      chk("wrap_pc", pc, 10'h000);
      chk("wrap_incr", incr_pc, 32'd0);

      foreach (tbl[i]) begin
         step(0, 0, 3'd2, 0, 10'h020, 0, 0);
         sel = 3'd1; jta = 10'h055; brc = tbl[i].b; flags = tbl[i].f;
         #1;
         chk("tbl_taken", taken, tbl[i].tk);
         step(0, 0, 3'd1, 10'h055, 0, tbl[i].b, tbl[i].f);
         chk("tbl_pc", pc, tbl[i].tk ? 10'h055 : 10'h021);
      end

      step(0, 0, 3'd2, 0, 10'h005, 0, 0);
      step(0, 0, 3'd4, 10'h100, 0, 0, 0);
      chk("call_pc", pc, 10'h100);
      chk("call_cnt", ras_count, 3'd1);
      step(0, 0, 3'd5, 0, 0, 0, 0);
      chk("ret_pc", pc, 10'h006);
      chk("ret_cnt", ras_count, 3'd0);

      step(0, 0, 3'd2, 0, 10'h010, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 3'd4, AW'(10'h200 + i), 0, 0, 0);
      chk("ovf_flag", ras_ovf, 1'b1);
      chk("ovf_cnt", ras_count, 3'd4);
      step(0, 0, 3'd5, 0, 0, 0, 0);
      chk("lifo0", pc, 10'h204);
      step(0, 0, 3'd5, 0, 0, 0, 0);
      chk("lifo1", pc, 10'h203);
      step(0, 0, 3'd5, 0, 0, 0, 0);
      chk("lifo2", pc, 10'h202);
      step(0, 0, 3'd5, 0, 0, 0, 0);
      chk("lifo3", pc, 10'h201);
      step(0, 0, 3'd5, 0, 0, 0, 0);
      chk("unf_pc", pc, 10'h202);
      chk("unf_flag", ras_unf, 1'b1);

      step(0, 0, 3'd2, 0, 10'h0AA, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 3'd4, 10'h155, 0, 0, 0);
         chk("stall_pc", pc, 10'h0AA);
         chk("stall_incr", incr_pc, 32'h203);
         chk("stall_cnt", ras_count, 3'd0);
      end
      sel = 3'd4; jta = 10'h155; stall = 1; rst = 0;
      #1;
      chk("stall_npc", next_pc, 10'h155);
      step(1, 1, 3'd4, 10'h155, 0, 0, 0);
      chk("rst_stall_pc", pc, RPC);
      chk("rst_stall_ovf", ras_ovf, 1'b0);
      chk("rst_stall_unf", ras_unf, 1'b0);

      for (int i = 0; i < 600; i++) begin
         step(($urandom % 50) == 0, ($urandom % 6) == 0,
              3'($urandom), AW'($urandom), AW'($urandom),
              4'($urandom), 4'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
